// File: rtl/fft_pkg.sv
// Shared types, sizes and helpers for the streaming FFT frame engine.
// Latency: none (declarations only).
// Backpressure: n/a.
package fft_pkg;

    localparam int DW        = 17;
    localparam int MAX_LOG2N = 7;
    localparam int MIN_LOG2N = 3;
    localparam int NMAX      = 1 << MAX_LOG2N;
    localparam int SW        = 2 * DW;
    localparam int FRAME_W   = NMAX * SW;
    localparam int IDX_W     = MAX_LOG2N;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } sample_t;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        CALC    = 2'd1,
        HANDOFF = 2'd2
    } in_state_t;

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } out_state_t;

    // Raise undersized requests to the smallest frame. A 3-bit field tops out
    // at 7, which is already MAX_LOG2N, so no upper clamp is needed.
    function automatic logic [2:0] clamp_log2n(input logic [2:0] v);
        if (v < 3'(MIN_LOG2N)) begin
            return 3'(MIN_LOG2N);
        end
        return v;
    endfunction

    // Index of the final sample of a 2^l2n point frame.
    function automatic logic [IDX_W-1:0] last_idx(input logic [2:0] l2n);
        return IDX_W'((8'd1 << l2n) - 8'd1);
    endfunction

endpackage

// File: rtl/fft_stream_frame_engine_if.sv
// Valid/ready sample stream carrying one complex {re, im} sample per beat.
// Latency: none (wires only).
// Backpressure: a beat transfers only when valid and ready are both high.
interface fft_stream_frame_engine_if;
    import fft_pkg::*;

    logic    valid;
    logic    ready;
    sample_t data;
    logic    last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/fft_frame_buf.sv
// One frame of sample storage: per-sample write with zero-fill above the write index, plus full-bus load/read.
// Latency: writes/loads land on the next clock edge; the read bus is the raw register contents.
// Backpressure: none; the owner decides when to write or load.
module fft_frame_buf
    import fft_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_wr_en,
    input  logic [IDX_W-1:0]   i_wr_idx,
    input  sample_t            i_wr_data,
    input  logic               i_zero_above,
    input  logic               i_load_en,
    input  logic [FRAME_W-1:0] i_load_frame,
    output logic [FRAME_W-1:0] o_frame
);

    sample_t r_mem [NMAX];

    // Storage update: a full load wins, otherwise one slot written and optionally everything above it cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NMAX; k++) begin
                r_mem[k] <= '0;
            end
        end else if (i_load_en) begin
            for (int k = 0; k < NMAX; k++) begin
                r_mem[k] <= i_load_frame[k*SW +: SW];
            end
        end else if (i_wr_en) begin
            for (int k = 0; k < NMAX; k++) begin
                if (IDX_W'(k) == i_wr_idx) begin
                    r_mem[k] <= i_wr_data;
                end else if (i_zero_above && (IDX_W'(k) > i_wr_idx)) begin
                    r_mem[k] <= '0;
                end
            end
        end
    end

    // Flatten the storage onto the parallel bus, sample k at [k*SW +: SW].
    always_comb begin
        o_frame = '0;
        for (int k = 0; k < NMAX; k++) begin
            o_frame[k*SW +: SW] = r_mem[k];
        end
    end

endmodule

// File: rtl/fft_stream_frame_engine.sv
// Serial-to-frame front end and frame-to-serial back end around an external parallel FFT core.
// Latency: capture at close edge + CORE_LAT + 1; first output valid in the cycle after that edge.
// Backpressure: in_ready drops from close until the result is handed to an idle output buffer; output holds on !out_ready.
module fft_stream_frame_engine
    import fft_pkg::*;
#(
    parameter int CORE_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2:0]                cfg_log2n,
    fft_stream_frame_engine_if.slave  in_if,
    fft_stream_frame_engine_if.master out_if,
    output logic [2:0]                core_log2n,
    output logic [FRAME_W-1:0]        core_frame_in,
    input  logic [FRAME_W-1:0]        core_frame_out,
    output logic                      err_short,
    output logic                      busy
);

    in_state_t        r_in_state;
    in_state_t        w_in_next;
    out_state_t       r_out_state;
    out_state_t       w_out_next;

    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic [2:0]       r_log2n;
    logic [2:0]       r_out_log2n;
    logic [3:0]       r_lat_cnt;
    logic             r_err_short;

    logic             w_in_rdy;
    logic             w_out_vld;
    logic             w_in_acc;
    logic [2:0]       w_frame_log2n;
    logic [IDX_W-1:0] w_in_last_idx;
    logic [IDX_W-1:0] w_core_last_idx;
    logic [IDX_W-1:0] w_out_last_idx;
    logic             w_close;
    logic             w_early;
    logic             w_out_acc;
    logic             w_out_final;
    logic             w_out_free;
    logic             w_capture;
    logic [FRAME_W-1:0] w_in_frame;
    logic [FRAME_W-1:0] w_out_frame;
    sample_t          w_rd_sample;

    // The frame size is taken from cfg on the first accept and held for the rest of the frame.
    assign w_in_acc        = in_if.valid && (r_in_state == FILL);
    assign w_frame_log2n   = (r_wr_idx == '0) ? clamp_log2n(cfg_log2n) : r_log2n;
    assign w_in_last_idx   = last_idx(w_frame_log2n);
    assign w_close         = w_in_acc && ((r_wr_idx == w_in_last_idx) || in_if.last);
    assign w_early         = w_close && (r_wr_idx != w_in_last_idx);

    // The output buffer is free if idle or if its final sample leaves this cycle (back-to-back drain).
    assign w_out_last_idx  = last_idx(r_out_log2n);
    assign w_out_acc       = (r_out_state == DRAIN) && out_if.ready;
    assign w_out_final     = w_out_acc && (r_rd_idx == w_out_last_idx);
    assign w_out_free      = (r_out_state == EMPTY) || w_out_final;
    assign w_capture       = (r_in_state == HANDOFF) && w_out_free;

    // Input FSM next state and ready.
    always_comb begin
        w_in_next = r_in_state;
        w_in_rdy  = 1'b0;
        unique case (r_in_state)
            FILL: begin
                w_in_rdy = 1'b1;
                if (w_close) begin
                    w_in_next = (CORE_LAT == 0) ? HANDOFF : CALC;
                end
            end
            CALC: begin
                if (r_lat_cnt == 4'(CORE_LAT)) begin
                    w_in_next = HANDOFF;
                end
            end
            HANDOFF: begin
                if (w_capture) begin
                    w_in_next = FILL;
                end
            end
            default: w_in_next = FILL;
        endcase
    end

    // Input FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_state <= FILL;
        end else begin
            r_in_state <= w_in_next;
        end
    end

    // Write index, latched frame size, core latency counter and short-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_idx    <= '0;
            r_log2n     <= 3'(MAX_LOG2N);
            r_lat_cnt   <= '0;
            r_err_short <= 1'b0;
        end else begin
            r_err_short <= w_early;
            if (w_capture) begin
                r_wr_idx <= '0;
            end else if (w_in_acc && !w_close) begin
                r_wr_idx <= r_wr_idx + IDX_W'(1);
            end
            if (w_in_acc && (r_wr_idx == '0)) begin
                r_log2n <= w_frame_log2n;
            end
            if (w_close) begin
                r_lat_cnt <= 4'd1;
            end else if (r_in_state == CALC) begin
                r_lat_cnt <= r_lat_cnt + 4'd1;
            end
        end
    end

    // Output FSM next state and valid.
    always_comb begin
        w_out_next = r_out_state;
        w_out_vld  = 1'b0;
        unique case (r_out_state)
            EMPTY: begin
                if (w_capture) begin
                    w_out_next = DRAIN;
                end
            end
            DRAIN: begin
                w_out_vld = 1'b1;
                if (w_capture) begin
                    w_out_next = DRAIN;
                end else if (w_out_final) begin
                    w_out_next = EMPTY;
                end
            end
            default: w_out_next = EMPTY;
        endcase
    end

    // Output FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_state <= EMPTY;
        end else begin
            r_out_state <= w_out_next;
        end
    end

    // Read index and the frame size of the frame being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_idx    <= '0;
            r_out_log2n <= 3'(MAX_LOG2N);
        end else if (w_capture) begin
            r_rd_idx    <= '0;
            r_out_log2n <= r_log2n;
        end else if (w_out_final) begin
            r_rd_idx    <= '0;
        end else if (w_out_acc) begin
            r_rd_idx    <= r_rd_idx + IDX_W'(1);
        end
    end

    fft_frame_buf u_in_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_en      (w_in_acc),
        .i_wr_idx     (r_wr_idx),
        .i_wr_data    (in_if.data),
        .i_zero_above (w_close),
        .i_load_en    (1'b0),
        .i_load_frame ('0),
        .o_frame      (w_in_frame)
    );

    fft_frame_buf u_out_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_en      (1'b0),
        .i_wr_idx     ('0),
        .i_wr_data    ('0),
        .i_zero_above (1'b0),
        .i_load_en    (w_capture),
        .i_load_frame (core_frame_out),
        .o_frame      (w_out_frame)
    );

    assign w_core_last_idx = last_idx(r_log2n);

    // Slots beyond the latched frame size never reach the core, even while a new frame is filling.
    always_comb begin
        core_frame_in = w_in_frame;
        for (int k = 0; k < NMAX; k++) begin
            if (IDX_W'(k) > w_core_last_idx) begin
                core_frame_in[k*SW +: SW] = '0;
            end
        end
    end

    assign w_rd_sample  = w_out_frame[r_rd_idx*SW +: SW];

    assign in_if.ready  = w_in_rdy;
    assign out_if.valid = w_out_vld;
    assign out_if.data  = w_out_vld ? w_rd_sample : '0;
    assign out_if.last  = w_out_vld && (r_rd_idx == w_out_last_idx);

    assign core_log2n   = r_log2n;
    assign err_short    = r_err_short;
    assign busy         = (r_in_state != FILL) || (r_wr_idx != '0) || (r_out_state != EMPTY);

endmodule

// File: tb/tb_fft_stream_frame_engine.sv
// Directed bench for fft_stream_frame_engine with a +1-per-component core model of latency 1.
// Latency: n/a.
// Backpressure: output ready driven always-high, toggling, or low from a mode variable.
module tb_fft_stream_frame_engine;
    import fft_pkg::*;

    logic               clk;
    logic               rst_n;
    logic [2:0]         cfg_log2n;
    logic [2:0]         core_log2n;
    logic [FRAME_W-1:0] core_frame_in;
    logic [FRAME_W-1:0] core_frame_out;
    logic               err_short;
    logic               busy;

    fft_stream_frame_engine_if in_if ();
    fft_stream_frame_engine_if out_if ();

    fft_stream_frame_engine #(.CORE_LAT(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_log2n      (cfg_log2n),
        .in_if          (in_if),
        .out_if         (out_if),
        .core_log2n     (core_log2n),
        .core_frame_in  (core_frame_in),
        .core_frame_out (core_frame_out),
        .err_short      (err_short),
        .busy           (busy)
    );

    int          n_assert;
    int          n_fail;
    int          rdy_mode;
    logic [34:0] q[$];
    logic [34:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: every component plus one, registered once.
    always @(posedge clk) begin
        for (int k = 0; k < NMAX; k++) begin
            core_frame_out[k*SW +: DW]    <= core_frame_in[k*SW +: DW] + DW'(1);
            core_frame_out[k*SW+DW +: DW] <= core_frame_in[k*SW+DW +: DW] + DW'(1);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv_i);
        n_assert++;
        assert (obs === expv_i) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv_i);
        end
    endtask

    function automatic logic [34:0] expv(input int re, input int im, input bit lst);
        logic [DW-1:0] r;
        logic [DW-1:0] i;
        r = DW'(re + 1);
        i = DW'(im + 1);
        return {lst, r, i};
    endfunction

    // Output ready pattern, changed just after each rising edge.
    initial begin
        out_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       out_if.ready = !out_if.ready;
                2:       out_if.ready = 1'b0;
                default: out_if.ready = 1'b1;
            endcase
        end
    end

    // Output monitor: record transfers and check hold-while-stalled.
    initial begin
        logic        stalled;
        logic [34:0] prev;
        stalled = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !out_if.valid) begin
                stalled = 1'b0;
            end else begin
                if (stalled) chk("stall_hold", {out_if.last, out_if.data}, prev);
                prev    = {out_if.last, out_if.data};
                stalled = !out_if.ready;
                if (out_if.ready) q.push_back(prev);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, failures so far=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic send(input int re, input int im, input logic lst, input logic [2:0] cfg);
        int t;
        in_if.valid = 1'b1;
        in_if.data  = {DW'(re), DW'(im)};
        in_if.last  = lst;
        cfg_log2n   = cfg;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_if.ready) break;
            t++;
            if (t > 3000) begin
                chk("send_timeout", in_if.ready, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        in_if.last  = 1'b0;
    endtask

    task automatic wait_out(input int n, input string tag);
        int t;
        t = 0;
        while (q.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (q.size() < n) chk({tag, "_timeout"}, q.size(), n);
        repeat (4) @(negedge clk);
        chk({tag, "_count"}, q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++) begin
            chk($sformatf("%s_out%0d", tag, i), q[i], exp_q[i]);
        end
        q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [FRAME_W-1:0] fr0;
        n_assert    = 0;
        n_fail      = 0;
        rdy_mode    = 0;
        rst_n       = 1'b1;
        cfg_log2n   = 3'd7;
        in_if.valid = 1'b0;
        in_if.data  = '0;
        in_if.last  = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_if.ready, 1);
        chk("rst_out_valid", out_if.valid, 0);
        chk("rst_out_last", out_if.last, 0);
        chk("rst_out_data", out_if.data, 0);
        chk("rst_err_short", err_short, 0);
        chk("rst_busy", busy, 0);
        chk("rst_core_log2n", core_log2n, 7);
        chk("rst_core_frame_zero", (core_frame_in == '0), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full 128-point frame, data {k, -k}.
        for (int k = 0; k < 128; k++) begin
            exp_q.push_back(expv(k, -k, k == 127));
            send(k, -k, 1'b0, 3'd7);
        end
        @(negedge clk);
        chk("t1_err_short", err_short, 0);
        chk("t1_valid_c1", out_if.valid, 0);
        chk("t1_busy", busy, 1);
        @(negedge clk);
        chk("t1_valid_c2", out_if.valid, 0);
        chk("t1_in_ready_handoff", in_if.ready, 0);
        @(negedge clk);
        chk("t1_valid_c3", out_if.valid, 1);
        chk("t1_in_ready_back", in_if.ready, 1);
        chk("t1_core_log2n", core_log2n, 7);
        wait_out(128, "t1");

        // Short 8-point frame closed by in_last on the 5th sample.
        for (int k = 0; k < 5; k++) begin
            send(k + 1, 0, k == 4, 3'd3);
        end
        @(negedge clk);
        chk("t2_err_pulse", err_short, 1);
        @(negedge clk);
        chk("t2_err_clear", err_short, 0);
        exp_q.push_back({1'b0, 17'd2, 17'd1});
        exp_q.push_back({1'b0, 17'd3, 17'd1});
        exp_q.push_back({1'b0, 17'd4, 17'd1});
        exp_q.push_back({1'b0, 17'd5, 17'd1});
        exp_q.push_back({1'b0, 17'd6, 17'd1});
        exp_q.push_back({1'b0, 17'd1, 17'd1});
        exp_q.push_back({1'b0, 17'd1, 17'd1});
        exp_q.push_back({1'b1, 17'd1, 17'd1});
        wait_out(8, "t2");

        // cfg 1 clamps to 8 points; a change to 7 mid-frame is ignored.
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(expv(10 + k, k, k == 7));
            send(10 + k, k, 1'b0, (k < 2) ? 3'd1 : 3'd7);
        end
        @(negedge clk);
        chk("t3_closed_at_8", in_if.ready, 0);
        chk("t3_core_log2n", core_log2n, 3);
        chk("t3_no_err", err_short, 0);
        wait_out(8, "t3");

        // Back-to-back 16-point frames with toggling output ready.
        rdy_mode = 1;
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(expv(100 + k, k, k == 15));
            send(100 + k, k, 1'b0, 3'd4);
        end
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(expv(200 + k, 50 + k, k == 15));
            send(200 + k, 50 + k, 1'b0, 3'd4);
        end
        repeat (3) @(negedge clk);
        chk("t4_wait_in_ready", in_if.ready, 0);
        chk("t4_wait_draining", out_if.valid, 1);
        chk("t4_wait_busy", busy, 1);
        chk("t4_slot15", core_frame_in[15*SW +: SW], {17'd215, 17'd65});
        chk("t4_slot16_zero", core_frame_in[16*SW +: SW], 0);
        fr0 = core_frame_in;
        repeat (3) @(negedge clk);
        chk("t4_frame_held", (core_frame_in == fr0), 1);
        chk("t4_still_waiting", in_if.ready, 0);
        wait_out(32, "t4");
        rdy_mode = 0;
        chk("t4_idle_ready", in_if.ready, 1);
        chk("t4_idle_busy", busy, 0);

        // Reset at input sample 40 of a 128-point frame.
        for (int k = 0; k < 40; k++) begin
            send(k, k, 1'b0, 3'd7);
        end
        chk("t5a_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5a_in_ready", in_if.ready, 1);
        chk("t5a_busy", busy, 0);
        chk("t5a_out_valid", out_if.valid, 0);
        chk("t5a_frame_zero", (core_frame_in == '0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset during a drain at rd_idx 10.
        for (int k = 0; k < 16; k++) begin
            send(k, k, 1'b0, 3'd4);
        end
        begin
            int t;
            t = 0;
            while (q.size() < 10 && t < 500) begin
                @(posedge clk);
                #1;
                t++;
            end
        end
        chk("t5b_at_10", q.size(), 10);
        chk("t5b_valid_before", out_if.valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t5b_out_valid", out_if.valid, 0);
        chk("t5b_out_data", out_if.data, 0);
        chk("t5b_out_last", out_if.last, 0);
        chk("t5b_busy", busy, 0);
        chk("t5b_core_log2n", core_log2n, 7);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Complete frame after reset.
        for (int k = 0; k < 128; k++) begin
            exp_q.push_back(expv(k + 3, 2 * k, k == 127));
            send(k + 3, 2 * k, 1'b0, 3'd7);
        end
        wait_out(128, "t5c");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
